fifo_stream_out: RTL and testbench

FIFO_STREAM_OUT -- requirements
Module: fifo_stream_out

---
 rtl/fifo_stream_out.sv | 101 ++++++++++
 tb/tb_fifo_stream_out.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_out.sv
// Show-ahead FIFO to valid/ready stream adapter with a 2-entry skid buffer,
// burst framing (m_last every BURST_LEN beats) and a wrapping burst counter.
module fifo_stream_out #(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             fifo_rd_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic [15:0]      burst_cnt
);

    localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [IDX_W-1:0] BEAT_RELOAD = IDX_W'(BURST_LEN - 1);

    // occ | meaning
    //  0  | buffer empty, m_valid low
    //  1  | head holds the presented beat
    //  2  | head presented, skid holds the next word, no further pops
    logic [1:0]       occ_q, occ_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [IDX_W-1:0] beat_rem_q, beat_rem_d;
    logic [15:0]      burst_cnt_q, burst_cnt_d;
    logic             run_q;
    logic             push;
    logic             pop;

    // run_q holds off popping on the first edge after reset release
    assign fifo_rd_en = run_q && !fifo_empty && !occ_q[1];
    assign m_valid    = (occ_q != 2'd0);
    assign m_data     = head_q;
    assign m_last     = m_valid && (beat_rem_q == '0);
    assign burst_cnt  = burst_cnt_q;

    assign push = fifo_rd_en;
    assign pop  = m_valid && m_ready;

    always_comb begin
        occ_d       = occ_q;
        head_d      = head_q;
        skid_d      = skid_q;
        beat_rem_d  = beat_rem_q;
        burst_cnt_d = burst_cnt_q;

        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase

        case (occ_q)
            2'd0: begin
                if (push) head_d = fifo_rd_data;
            end
            2'd1: begin
                if (push && pop)  head_d = fifo_rd_data;
                else if (push)    skid_d = fifo_rd_data;
            end
            2'd2: begin
                if (pop) head_d = skid_q;
            end
            default: ;
        endcase

        // Beat position is a down-counter; terminal count marks the last beat
        if (pop) begin
            if (beat_rem_q == '0) begin
                beat_rem_d  = BEAT_RELOAD;
                burst_cnt_d = burst_cnt_q + 16'd1;
            end else begin
                beat_rem_d = beat_rem_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q       <= 2'd0;
            head_q      <= '0;
            skid_q      <= '0;
            beat_rem_q  <= BEAT_RELOAD;
            burst_cnt_q <= 16'd0;
            run_q       <= 1'b0;
        end else begin
            occ_q       <= occ_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            beat_rem_q  <= beat_rem_d;
            burst_cnt_q <= burst_cnt_d;
            run_q       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_stream_out.sv
// Randomized and directed bench for fifo_stream_out against a queue-based
// model of the buffered stream, burst position and burst count.
module tb_fifo_stream_out;

    localparam int WIDTH = 8;
    localparam int BL    = 4;

    logic             clk;
    logic             rst_n;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rd_data;
    logic             fifo_rd_en;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic [15:0]      burst_cnt;

    fifo_stream_out #(.WIDTH(WIDTH), .BURST_LEN(BL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .burst_cnt    (burst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [WIDTH-1:0] src[$];
    logic [WIDTH-1:0] mbuf[$];
    logic [WIDTH-1:0] obs_d[$];
    logic             obs_l[$];
    logic             gate;
    int               m_idx;
    logic [15:0]      m_burst;
    int               m_total;
    logic             m_run;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        fifo_empty   = gate || (src.size() == 0);
        fifo_rd_data = (src.size() != 0) ? src[0] : WIDTH'($urandom);
    endtask

    task automatic model_clear();
        mbuf.delete();
        m_idx   = 0;
        m_burst = 16'd0;
        m_total = 0;
        m_run   = 1'b0;
    endtask

    task automatic model_edge();
        logic xfer;
        logic pop;
        if (!rst_n) return;
        xfer = (mbuf.size() != 0) && m_ready;
        pop  = m_run && !fifo_empty && (mbuf.size() < 2);
        if (xfer) begin
            void'(mbuf.pop_front());
            m_total++;
            if (m_idx == BL - 1) begin
                m_idx = 0;
                m_burst++;
            end else begin
                m_idx++;
            end
        end
        if (pop) mbuf.push_back(src.pop_front());
        m_run = 1'b1;
    endtask

    // One clock: check at negedge, advance model at posedge, re-drive inputs
    task automatic step();
        logic ev;
        @(negedge clk);
        ev = (mbuf.size() != 0);
        chk("m_valid", {31'd0, m_valid}, {31'd0, ev});
        chk("m_last", {31'd0, m_last}, {31'd0, ev && (m_idx == BL - 1)});
        chk("fifo_rd_en", {31'd0, fifo_rd_en},
            {31'd0, m_run && rst_n && !fifo_empty && (mbuf.size() < 2)});
        chk("burst_cnt", {16'd0, burst_cnt}, {16'd0, m_burst});
        if (!rst_n)  chk("m_data_rst", {24'd0, m_data}, 32'd0);
        else if (ev) chk("m_data", {24'd0, m_data}, {24'd0, mbuf[0]});
        if (m_valid && m_ready) begin
            obs_d.push_back(m_data);
            obs_l.push_back(m_last);
        end
        @(posedge clk);
        model_edge();
        #1;
        drive();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Entered just after a posedge; asserts reset between edges
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_last", {31'd0, m_last}, 32'd0);
        chk("rst_m_data", {24'd0, m_data}, 32'd0);
        chk("rst_burst_cnt", {16'd0, burst_cnt}, 32'd0);
        chk("rst_fifo_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        steps(2);
        rst_n = 1'b1;
        drive();
    endtask

    task automatic load(input int first, input int n);
        for (int i = 0; i < n; i++) src.push_back(WIDTH'(first + i));
        drive();
    endtask

    initial begin
        rst_n   = 1'b0;
        gate    = 1'b0;
        m_ready = 1'b0;
        model_clear();
        drive();
        #1;
        steps(2);
        rst_n = 1'b1;
        drive();

        // Stream: 0x01..0x08 back to back
        do_reset();
        src.delete(); obs_d.delete(); obs_l.delete();
        m_ready = 1'b1;
        load(1, 8);
        steps(14);
        chk("stream_count", obs_d.size(), 8);
        for (int i = 0; i < obs_d.size() && i < 8; i++) begin
            chk("stream_data", {24'd0, obs_d[i]}, i + 1);
            chk("stream_last", {31'd0, obs_l[i]}, (i == 3 || i == 7) ? 32'd1 : 32'd0);
        end
        chk("stream_bursts", {16'd0, burst_cnt}, 2);

        // Backpressure: stall 5 cycles, then drain gap-free
        do_reset();
        src.delete(); obs_d.delete(); obs_l.delete();
        m_ready = 1'b0;
        load(1, 8);
        steps(7);
        chk("bp_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("bp_frozen", {24'd0, m_data}, 32'd1);
        m_ready = 1'b1;
        steps(8);
        chk("bp_count", obs_d.size(), 8);
        for (int i = 0; i < obs_d.size() && i < 8; i++)
            chk("bp_data", {24'd0, obs_d[i]}, i + 1);

        // Starvation: 2 words, empty gap, 2 words
        do_reset();
        src.delete(); obs_d.delete(); obs_l.delete();
        m_ready = 1'b1;
        load(8'h21, 2);
        steps(7);
        load(8'h23, 2);
        steps(6);
        chk("starve_count", obs_d.size(), 4);
        for (int i = 0; i < obs_l.size() && i < 4; i++)
            chk("starve_last", {31'd0, obs_l[i]}, (i == 3) ? 32'd1 : 32'd0);

        // Reset mid-burst with occ=2, beat_idx=2
        do_reset();
        src.delete(); obs_d.delete(); obs_l.delete();
        m_ready = 1'b1;
        load(8'h10, 8);
        steps(4);
        m_ready = 1'b0;
        drive();
        steps(2);
        do_reset();
        obs_d.delete(); obs_l.delete();
        m_ready = 1'b1;
        drive();
        steps(4);
        chk("post_rst_seen", {31'd0, obs_l.size() != 0}, 32'd1);
        if (obs_l.size() != 0) chk("post_rst_last", {31'd0, obs_l[0]}, 32'd0);
        chk("post_rst_bursts", {16'd0, burst_cnt}, 32'd0);

        // Random traffic
        do_reset();
        src.delete();
        for (int c = 0; c < 10000; c++) begin
            if (src.size() < 4 && $urandom_range(0, 2) != 0) src.push_back(WIDTH'($urandom));
            gate    = ($urandom_range(0, 3) == 0);
            m_ready = ($urandom_range(0, 3) != 0);
            drive();
            step();
        end
        chk("rand_bursts", {16'd0, burst_cnt}, {16'd0, 16'(m_total / BL)});
        gate = 1'b0;

        // Wrap: preload burst counter one below wrap, finish one burst
        do_reset();
        src.delete();
        force dut.burst_cnt_q = 16'hFFFF;
        #1;
        release dut.burst_cnt_q;
        m_burst = 16'hFFFF;
        m_ready = 1'b1;
        load(8'h40, BL);
        steps(BL + 4);
        chk("wrap_burst_cnt", {16'd0, burst_cnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
